// File: rtl/reg_hazard_tracker_if.sv
// D-stage hazard query bus and the tracker's stall/forward answers.
interface reg_hazard_tracker_if;
  logic       d_valid;
  logic [4:0] d_rs_addr;
  logic [4:0] d_rt_addr;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic [4:0] d_wr_addr;
  logic [1:0] d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs_sel;
  logic [1:0] fwd_d_rt_sel;
  logic [1:0] fwd_e_rs_sel;
  logic [1:0] fwd_e_rt_sel;
  logic [4:0] e_wr_addr;
  logic [4:0] m_wr_addr;
  logic [4:0] w_wr_addr;

  modport master (
    output d_valid, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, d_wr_addr, d_tnew,
    input  stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel,
           e_wr_addr, m_wr_addr, w_wr_addr
  );

  modport slave (
    input  d_valid, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, d_wr_addr, d_tnew,
    output stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel,
           e_wr_addr, m_wr_addr, w_wr_addr
  );
endinterface

// File: rtl/reg_hazard_tracker.sv
// Register hazard tracker: follows destination registers through E/M/W,
// raises stall when a D operand's producer cannot deliver in time, and
// picks the forwarding source for D and E operands.
module reg_hazard_tracker (
  input  logic                 clk,
  input  logic                 reset,
  reg_hazard_tracker_if.slave  hif
);

  logic [4:0] e_addr, e_rs, e_rt, m_addr, w_addr;
  logic [1:0] e_tnew, m_tnew;
  // W's tnew is always 0 by construction (E tnew <= 2, two decrements to W),
  // so W holds no tnew register: a W match is always forwardable.

  logic [1:0] d_tnew_sat;
  logic [1:0] e_tnew_dec, m_tnew_dec;
  logic       load_e;

  assign d_tnew_sat = (hif.d_tnew == 2'd3) ? 2'd2 : hif.d_tnew;
  assign e_tnew_dec = (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
  assign m_tnew_dec = (m_tnew == 2'd0) ? 2'd0 : m_tnew - 2'd1;
  assign load_e     = hif.d_valid && !hif.stall;

  // Stage advance: M->W and E->M always move; E takes D or a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_addr <= '0; e_tnew <= '0; e_rs <= '0; e_rt <= '0;
      m_addr <= '0; m_tnew <= '0;
      w_addr <= '0;
    end else begin
      w_addr <= m_addr;
      m_addr <= e_addr;
      m_tnew <= e_tnew_dec;
      if (load_e) begin
        e_addr <= hif.d_wr_addr;
        e_tnew <= d_tnew_sat;
        e_rs   <= hif.d_rs_addr;
        e_rt   <= hif.d_rt_addr;
      end else begin
        e_addr <= '0; e_tnew <= '0; e_rs <= '0; e_rt <= '0;
      end
    end
  end

  // $0 is hard-wired zero, so it never names a real producer.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // Youngest matching producer decides; if it is not ready, stall covers it.
  function automatic logic [1:0] d_sel(input logic [4:0] src);
    if (hit(src, e_addr))      return (e_tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (hit(src, m_addr)) return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(src, w_addr)) return 2'd3;
    else                       return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] src);
    if (hit(src, m_addr))      return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (hit(src, w_addr)) return 2'd3;
    else                       return 2'd0;
  endfunction

  function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse);
    if (tuse == 2'd3) return 1'b0;
    return (hit(src, e_addr) && (e_tnew > tuse)) ||
           (hit(src, m_addr) && (m_tnew > tuse));
  endfunction

  // Zero-latency hazard answers; forced quiet while reset is held.
  always_comb begin
    hif.stall        = 1'b0;
    hif.fwd_d_rs_sel = 2'd0;
    hif.fwd_d_rt_sel = 2'd0;
    hif.fwd_e_rs_sel = 2'd0;
    hif.fwd_e_rt_sel = 2'd0;
    if (!reset) begin
      hif.stall        = src_stall(hif.d_rs_addr, hif.d_rs_tuse) ||
                         src_stall(hif.d_rt_addr, hif.d_rt_tuse);
      hif.fwd_d_rs_sel = d_sel(hif.d_rs_addr);
      hif.fwd_d_rt_sel = d_sel(hif.d_rt_addr);
      hif.fwd_e_rs_sel = e_sel(e_rs);
      hif.fwd_e_rt_sel = e_sel(e_rt);
    end
  end

  assign hif.e_wr_addr = e_addr;
  assign hif.m_wr_addr = m_addr;
  assign hif.w_wr_addr = w_addr;

endmodule

// File: tb/tb_reg_hazard_tracker.sv
// Directed hazard scenarios plus randomized traffic against an age-based
// reference model of in-flight producers.
module tb_reg_hazard_tracker;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  reg_hazard_tracker_if hif ();
  reg_hazard_tracker dut (.clk(clk), .reset(reset), .hif(hif));

  always #5 clk = ~clk;

  // In-flight producers by age (0=E,1=M,2=W): issue tnew, dest and sources.
  int p_addr[3];
  int p_tnew[3];
  int p_rs[3];
  int p_rt[3];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rem(input int i);
    return (p_tnew[i] > i) ? p_tnew[i] - i : 0;
  endfunction

  function automatic bit hit(input int i, input int a);
    return a != 0 && p_addr[i] == a;
  endfunction

  function automatic int sel_from(input int first, input int a);
    for (int i = first; i < 3; i++)
      if (hit(i, a)) return (rem(i) == 0) ? i + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_stall();
    int a[2];
    int t[2];
    a[0] = hif.d_rs_addr; t[0] = hif.d_rs_tuse;
    a[1] = hif.d_rt_addr; t[1] = hif.d_rt_tuse;
    for (int s = 0; s < 2; s++)
      if (t[s] != 3)
        for (int i = 0; i < 2; i++)
          if (hit(i, a[s]) && rem(i) > t[s]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) begin
      p_addr[i] = 0; p_tnew[i] = 0; p_rs[i] = 0; p_rt[i] = 0;
    end
  endtask

  task automatic m_check();
    chk("stall",    int'(hif.stall),        int'(m_stall()));
    chk("fwd_d_rs", int'(hif.fwd_d_rs_sel), sel_from(0, hif.d_rs_addr));
    chk("fwd_d_rt", int'(hif.fwd_d_rt_sel), sel_from(0, hif.d_rt_addr));
    chk("fwd_e_rs", int'(hif.fwd_e_rs_sel), sel_from(1, p_rs[0]));
    chk("fwd_e_rt", int'(hif.fwd_e_rt_sel), sel_from(1, p_rt[0]));
    chk("e_wr",     int'(hif.e_wr_addr),    p_addr[0]);
    chk("m_wr",     int'(hif.m_wr_addr),    p_addr[1]);
    chk("w_wr",     int'(hif.w_wr_addr),    p_addr[2]);
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int rsu,
                       input int rtu, input int wr, input int tn);
    hif.d_valid   = v;
    hif.d_rs_addr = 5'(rs);
    hif.d_rt_addr = 5'(rt);
    hif.d_rs_tuse = 2'(rsu);
    hif.d_rt_tuse = 2'(rtu);
    hif.d_wr_addr = 5'(wr);
    hif.d_tnew    = 2'(tn);
  endtask

  // Model check at the sampling point, then clock edge and model advance.
  task automatic tick();
    bit st;
    m_check();
    st = m_stall();
    @(posedge clk);
    if (reset) m_clear();
    else begin
      for (int i = 2; i > 0; i--) begin
        p_addr[i] = p_addr[i-1]; p_tnew[i] = p_tnew[i-1];
        p_rs[i] = p_rs[i-1];     p_rt[i] = p_rt[i-1];
      end
      if (hif.d_valid && !st) begin
        p_addr[0] = hif.d_wr_addr;
        p_tnew[0] = (hif.d_tnew == 2'd3) ? 2 : int'(hif.d_tnew);
        p_rs[0]   = hif.d_rs_addr;
        p_rt[0]   = hif.d_rt_addr;
      end else begin
        p_addr[0] = 0; p_tnew[0] = 0; p_rs[0] = 0; p_rt[0] = 0;
      end
    end
    #1;
  endtask

  task automatic flush();
    drive(0, 0, 0, 3, 3, 0, 0);
    repeat (3) begin @(negedge clk); tick(); end
  endtask

  initial begin
    m_clear();
    reset = 1'b1;
    drive(1, 8, 9, 0, 0, 8, 2);
    #3;
    chk("rst_stall", int'(hif.stall), 0);
    chk("rst_w_wr",  int'(hif.w_wr_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    flush();

    // Load-use: lw $8 (tnew 2), then reader of $8 with tuse 1.
    drive(1, 0, 0, 3, 3, 8, 2); @(negedge clk); tick();
    drive(1, 8, 0, 1, 3, 11, 1); @(negedge clk);
    chk("lu_stall1", int'(hif.stall), 1); tick();
    @(negedge clk);
    chk("lu_stall0", int'(hif.stall), 0);
    chk("lu_fwd_d", int'(hif.fwd_d_rs_sel), 0); tick();
    drive(0, 0, 0, 3, 3, 0, 0); @(negedge clk);
    chk("lu_fwd_e", int'(hif.fwd_e_rs_sel), 3); tick();
    flush();

    // ALU back-to-back through rt.
    drive(1, 0, 0, 3, 3, 9, 1); @(negedge clk); tick();
    drive(1, 0, 9, 3, 1, 12, 1); @(negedge clk);
    chk("alu_stall", int'(hif.stall), 0); tick();
    drive(0, 0, 0, 3, 3, 0, 0); @(negedge clk);
    chk("alu_fwd_e_rt", int'(hif.fwd_e_rt_sel), 2); tick();
    flush();

    // Branch right after ALU producer.
    drive(1, 0, 0, 3, 3, 10, 1); @(negedge clk); tick();
    drive(1, 10, 0, 0, 3, 0, 0); @(negedge clk);
    chk("br_stall1", int'(hif.stall), 1); tick();
    @(negedge clk);
    chk("br_stall0", int'(hif.stall), 0);
    chk("br_fwd_d", int'(hif.fwd_d_rs_sel), 2); tick();
    flush();

    // $0 producer and $0 reader never interact.
    drive(1, 0, 0, 3, 3, 0, 2); @(negedge clk); tick();
    drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("z_stall", int'(hif.stall), 0);
    chk("z_fwd_rs", int'(hif.fwd_d_rs_sel), 0);
    chk("z_fwd_rt", int'(hif.fwd_d_rt_sel), 0); tick();
    flush();

    // E and M both hold ready $5: E wins.
    drive(1, 0, 0, 3, 3, 5, 0); @(negedge clk); tick();
    @(negedge clk); tick();
    drive(1, 5, 0, 1, 3, 0, 0); @(negedge clk);
    chk("prio_fwd_d", int'(hif.fwd_d_rs_sel), 1); tick();
    flush();

    // Reset asserted mid-stall drops everything immediately.
    drive(1, 0, 0, 3, 3, 21, 0); @(negedge clk); tick();
    drive(1, 0, 0, 3, 3, 20, 2); @(negedge clk); tick();
    drive(1, 20, 0, 0, 3, 0, 0); @(negedge clk); tick();
    @(negedge clk);
    chk("rs_stall_pre", int'(hif.stall), 1);
    chk("rs_w_pre", int'(hif.w_wr_addr), 21);
    reset = 1'b1; #1;
    chk("rs_stall_now", int'(hif.stall), 0);
    chk("rs_w_now", int'(hif.w_wr_addr), 0);
    m_clear();
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized traffic over a small register range to force collisions.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1; #1;
        m_clear();
        @(negedge clk); m_check();
        @(posedge clk); #1;
        reset = 1'b0;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 3));
      @(negedge clk);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
